hazard_scoreboard_unit: RTL and testbench

//  Parametrised ID-stage hazard unit built on a per-register countdown scoreboard.
//  It replaces opcode-pattern matching with latency tracking for ALU, LW and multi-cycle MUL writers.
//  It detects load-use, branch-in-ID operand and WAW (slow MUL vs fast writer) hazards and drives PC/ID freeze plus an ID/EX bubble.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/haz_sb_entry.sv | 33 +++
 rtl/hazard_scoreboard_unit.sv | 127 ++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the scoreboard-based ID-stage hazard unit:
// writer-class encodings, the class-to-latency mapping and the stats width.
package hazard_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MUL  = 2'd2,
    CLS_RSVD = 2'd3
  } wr_class_e;

  localparam int STATS_W = 32;

  // Cycles from EX entry until a writer of this class is forwardable.
  // The reserved encoding behaves like an ALU writer.
  function automatic int lat(input logic [1:0] cls, input int alu_lat,
                             input int load_lat, input int mul_lat);
    if (cls == CLS_LOAD) return load_lat;
    else if (cls == CLS_MUL) return mul_lat;
    else return alu_lat;
  endfunction

endpackage

// File: rtl/haz_sb_entry.sv
// One scoreboard slot: a down-counter that reloads on a new write,
// otherwise counts toward zero, and freezes while hold is high.
module haz_sb_entry #(
  parameter int CNT_W = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             hold,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: a new write overrides the decrement; zero is sticky.
  always_comb begin
    cnt_d = cnt_q;
    if (!hold) begin
      if (load) cnt_d = load_val;
      else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit using a per-register countdown scoreboard.
// Detects load-use / multi-cycle operand hazards, branch-in-ID operand
// hazards and WAW hazards, and freezes PC/ID while bubbling ID/EX.
// Optional stall statistics are built when HAZ_STALL_STATS_EN is defined;
// otherwise the Stall_cnt_* outputs are constant zero.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_COUNT = 32,
  parameter int REG_AW    = 5,
  parameter int ALU_LAT   = 1,
  parameter int LOAD_LAT  = 2,
  parameter int MUL_LAT   = 4,
  parameter int CNT_W     = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               ID_valid,
  input  logic [REG_AW-1:0]  ID_rs,
  input  logic [REG_AW-1:0]  ID_rt,
  input  logic               ID_rs_used,
  input  logic               ID_rt_used,
  input  logic               ID_is_branch,
  input  logic               ID_wr_en,
  input  logic [REG_AW-1:0]  ID_rDest,
  input  logic [1:0]         ID_class,
  input  logic               Ext_stall,
  output logic               Stall_PC,
  output logic               Stall_ID,
  output logic               Stall_ID_EX,
  output logic [STATS_W-1:0] Stall_cnt_lu,
  output logic [STATS_W-1:0] Stall_cnt_br,
  output logic [STATS_W-1:0] Stall_cnt_waw
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_all [REG_COUNT];
  logic [CNT_W-1:0] lat_id;
  logic [CNT_W-1:0] cnt_rs, cnt_rt, cnt_rd;
  logic             rs_live, rt_live, rd_live;
  logic             haz_ex, haz_br, haz_waw;
  logic             stall, issue, wr_go;

  // r0 is never tracked; reading its slot always yields "nothing pending".
  assign cnt_all[0] = '0;

  assign lat_id = CNT_W'(lat(ID_class, ALU_LAT, LOAD_LAT, MUL_LAT));

  // Hazard detection from the scoreboard and the instruction in ID.
  always_comb begin
    rs_live = ID_rs_used && (ID_rs != '0);
    rt_live = ID_rt_used && (ID_rt != '0);
    rd_live = ID_wr_en && (ID_rDest != '0);
    cnt_rs  = cnt_all[ID_rs];
    cnt_rt  = cnt_all[ID_rt];
    cnt_rd  = cnt_all[ID_rDest];
    haz_ex  = ID_valid && !ID_is_branch &&
              ((rs_live && (cnt_rs > CNT_ONE)) || (rt_live && (cnt_rt > CNT_ONE)));
    haz_br  = ID_valid && ID_is_branch &&
              ((rs_live && (cnt_rs != '0)) || (rt_live && (cnt_rt != '0)));
    haz_waw = ID_valid && rd_live && (cnt_rd > lat_id);
    stall   = haz_ex || haz_br || haz_waw;
    issue   = ID_valid && !stall && !Ext_stall;
    wr_go   = issue && rd_live;
  end

  assign Stall_PC    = stall;
  assign Stall_ID    = stall;
  assign Stall_ID_EX = stall;

  // One countdown slot per tracked register r1..REG_COUNT-1.
  for (genvar r = 1; r < REG_COUNT; r++) begin : g_sb
    haz_sb_entry #(.CNT_W(CNT_W)) u_entry (
      .Clock    (Clock),
      .Reset    (Reset),
      .hold     (Ext_stall),
      .load     (wr_go && (ID_rDest == REG_AW'(r))),
      .load_val (lat_id),
      .cnt      (cnt_all[r])
    );
  end

`ifdef HAZ_STALL_STATS_EN
  logic [STATS_W-1:0] stat_lu_q, stat_lu_d;
  logic [STATS_W-1:0] stat_br_q, stat_br_d;
  logic [STATS_W-1:0] stat_waw_q, stat_waw_d;

  // Attribute each effective stall cycle to one cause: br, then lu, then waw.
  always_comb begin
    stat_lu_d  = stat_lu_q;
    stat_br_d  = stat_br_q;
    stat_waw_d = stat_waw_q;
    if (stall && !Ext_stall) begin
      if (haz_br) begin
        if (stat_br_q != '1) stat_br_d = stat_br_q + 1'b1;
      end else if (haz_ex) begin
        if (stat_lu_q != '1) stat_lu_d = stat_lu_q + 1'b1;
      end else begin
        if (stat_waw_q != '1) stat_waw_d = stat_waw_q + 1'b1;
      end
    end
  end

  // Saturating stall statistics registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stat_lu_q  <= '0;
      stat_br_q  <= '0;
      stat_waw_q <= '0;
    end else begin
      stat_lu_q  <= stat_lu_d;
      stat_br_q  <= stat_br_d;
      stat_waw_q <= stat_waw_d;
    end
  end

  assign Stall_cnt_lu  = stat_lu_q;
  assign Stall_cnt_br  = stat_br_q;
  assign Stall_cnt_waw = stat_waw_q;
`else
  assign Stall_cnt_lu  = '0;
  assign Stall_cnt_br  = '0;
  assign Stall_cnt_waw = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed scenarios with literal stall
// expectations plus randomized traffic, all checked every cycle against a
// model that tracks, per register, the cycle at which its value becomes ready.
module tb_hazard_scoreboard_unit;

`ifdef HAZ_STALL_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ID_valid, ID_rs_used, ID_rt_used, ID_is_branch, ID_wr_en, Ext_stall;
  logic [4:0]  ID_rs, ID_rt, ID_rDest;
  logic [1:0]  ID_class;
  logic        Stall_PC, Stall_ID, Stall_ID_EX;
  logic [31:0] Stall_cnt_lu, Stall_cnt_br, Stall_cnt_waw;

  int errors = 0;
  int checks = 0;

  // Model: avail[r] = model tick at which r becomes forwardable.
  int avail [32];
  int tick = 0;
  int m_lu = 0, m_br = 0, m_waw = 0;

  always #5 Clock = ~Clock;

  hazard_scoreboard_unit dut (
    .Clock(Clock), .Reset(Reset), .ID_valid(ID_valid),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used),
    .ID_is_branch(ID_is_branch), .ID_wr_en(ID_wr_en), .ID_rDest(ID_rDest),
    .ID_class(ID_class), .Ext_stall(Ext_stall),
    .Stall_PC(Stall_PC), .Stall_ID(Stall_ID), .Stall_ID_EX(Stall_ID_EX),
    .Stall_cnt_lu(Stall_cnt_lu), .Stall_cnt_br(Stall_cnt_br), .Stall_cnt_waw(Stall_cnt_waw)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rem(input int r);
    if (r == 0) return 0;
    return (avail[r] > tick) ? avail[r] - tick : 0;
  endfunction

  function automatic int latm(input int c);
    if (c == 1) return 2;
    if (c == 2) return 4;
    return 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) avail[i] = 0;
    m_lu = 0; m_br = 0; m_waw = 0;
  endtask

  task automatic chk_stats();
    chk("cnt_lu",  Stall_cnt_lu,  STATS_ON ? 32'(m_lu)  : 32'd0);
    chk("cnt_br",  Stall_cnt_br,  STATS_ON ? 32'(m_br)  : 32'd0);
    chk("cnt_waw", Stall_cnt_waw, STATS_ON ? 32'(m_waw) : 32'd0);
  endtask

  // One cycle: drive ID, check outputs against the model (and exp_lit if >=0),
  // then advance the model across the clock edge.
  task automatic step(input int v, input int rs, input int rt, input int ru, input int tu,
                      input int br, input int we, input int rd, input int cls,
                      input int ext, input int exp_lit);
    bit hx, hb, hw, st, iss;
    ID_valid = 1'(v); ID_rs = 5'(rs); ID_rt = 5'(rt);
    ID_rs_used = 1'(ru); ID_rt_used = 1'(tu); ID_is_branch = 1'(br);
    ID_wr_en = 1'(we); ID_rDest = 5'(rd); ID_class = 2'(cls); Ext_stall = 1'(ext);
    #1;
    hx = (v != 0) && (br == 0) && (((ru != 0) && rem(rs) > 1) || ((tu != 0) && rem(rt) > 1));
    hb = (v != 0) && (br != 0) && (((ru != 0) && rem(rs) >= 1) || ((tu != 0) && rem(rt) >= 1));
    hw = (v != 0) && (we != 0) && (rd != 0) && (rem(rd) > latm(cls));
    st = hx || hb || hw;
    chk("stall_pc", 32'(Stall_PC), 32'(st));
    chk("stall_id", 32'(Stall_ID), 32'(st));
    chk("stall_idex", 32'(Stall_ID_EX), 32'(st));
    if (exp_lit >= 0) chk("lit_stall", 32'(Stall_PC), 32'(exp_lit));
    chk_stats();
    iss = (v != 0) && !st && (ext == 0);
    if (st && ext == 0) begin
      if (hb) m_br++;
      else if (hx) m_lu++;
      else m_waw++;
    end
    @(posedge Clock);
    if (ext == 0) begin
      tick++;
      if (iss && we != 0 && rd != 0) avail[rd] = tick + latm(cls);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    Reset = 1'b0;
    ID_valid = 0; ID_rs = 0; ID_rt = 0; ID_rs_used = 0; ID_rt_used = 0;
    ID_is_branch = 0; ID_wr_en = 0; ID_rDest = 0; ID_class = 0; Ext_stall = 0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_stall", 32'(Stall_PC), 32'd0);
    chk_stats();
    Reset = 1'b1;
    #1;

    // Reset asserted in the middle of a branch operand stall.
    step(1, 0, 0, 0, 0, 0, 1, 8, 1, 0, 0);   // LW r8
    step(1, 8, 0, 1, 0, 1, 0, 0, 0, 0, 1);   // beq r8: first stall, inputs held
    chk("pre_rst_stall", 32'(Stall_PC), 32'd1);
    Reset = 1'b0;
    #1;
    chk("async_rst_pc", 32'(Stall_PC), 32'd0);
    chk("async_rst_id", 32'(Stall_ID), 32'd0);
    chk("async_rst_idex", 32'(Stall_ID_EX), 32'd0);
    model_reset();
    chk_stats();
    @(posedge Clock);
    #1;
    chk("in_rst_stall", 32'(Stall_PC), 32'd0);
    Reset = 1'b1;
    #1;
    step(1, 8, 0, 1, 0, 1, 0, 0, 0, 0, 0);   // scoreboard was cleared
    idle(2);

    // LW r8 then ALU reading r8: one stall.
    step(1, 0, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    step(1, 0, 8, 0, 1, 0, 1, 11, 0, 0, 1);
    step(1, 0, 8, 0, 1, 0, 1, 11, 0, 0, 0);
    chk("lit_lu_stat", Stall_cnt_lu, STATS_ON ? 32'd1 : 32'd0);
    idle(3);

    // ALU r9 then beq r9: one stall; LW r9 then beq r9: two stalls.
    step(1, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    step(1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 1);
    step(1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 9, 1, 0, 0);
    step(1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 1);
    step(1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 1);
    step(1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    chk("lit_br_stat", Stall_cnt_br, STATS_ON ? 32'd3 : 32'd0);
    idle(3);

    // MUL r10 then ALU writing r10: WAW stalls while cnt > 1.
    step(1, 0, 0, 0, 0, 0, 1, 10, 2, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 10, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1, 10, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1, 10, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0);
    idle(3);
    // MUL r10 then ALU reading r10 (rs==rt): MUL_LAT-1 stalls.
    step(1, 0, 0, 0, 0, 0, 1, 10, 2, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 10, 10, 1, 1, 0, 1, 12, 0, 0, 1);
    step(1, 10, 10, 1, 1, 0, 1, 12, 0, 0, 0);
    idle(3);

    // LW r8 then dependent op frozen by Ext_stall, then released.
    step(1, 0, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 8, 0, 1, 0, 0, 1, 13, 0, 1, 1);
    step(1, 8, 0, 1, 0, 0, 1, 13, 0, 0, 1);
    step(1, 8, 0, 1, 0, 0, 1, 13, 0, 0, 0);
    idle(3);

    // r0 writes/reads never stall; flushed LW is not recorded.
    step(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    step(1, 8, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    // Invalid ID with a pending hazard: outputs stay low.
    step(1, 0, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    step(0, 8, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    idle(3);

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) < 85) ? 1 : 0,
           $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 99) < 25) ? 1 : 0,
           $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3),
           ($urandom_range(0, 99) < 15) ? 1 : 0, -1);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
